// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the TX arbiter, its two requester FIFOs and the UART
// transmitter; master is the arbiter side.
interface uart_tx_arbiter_if;
  logic       a_empty;
  logic [7:0] a_data;
  logic       a_rd_en;
  logic       b_empty;
  logic [7:0] b_data;
  logic       b_rd_en;
  logic       tx_done;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic [1:0] grant;
  logic       busy;

  modport master (
    input  a_empty,
    input  a_data,
    input  b_empty,
    input  b_data,
    input  tx_done,
    output a_rd_en,
    output b_rd_en,
    output tx_valid,
    output tx_data,
    output grant,
    output busy
  );

  modport slave (
    output a_empty,
    output a_data,
    output b_empty,
    output b_data,
    output tx_done,
    input  a_rd_en,
    input  b_rd_en,
    input  tx_valid,
    input  tx_data,
    input  grant,
    input  busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from two byte FIFOs,
// handing the line over after PKT_LEN bytes or when the owner drains.
module uart_tx_arbiter #(
  parameter int unsigned PKT_LEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LOAD,
    SEND,
    WAIT
  } state_e;

  localparam logic [7:0] LenLimit = 8'(PKT_LEN);

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       prio_q, prio_d;

  logic [7:0] cnt_inc;
  logic       own_empty;
  logic       pick_a;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      prio_q  <= prio_d;
    end
  end

  assign cnt_inc   = cnt_q + 8'd1;
  assign own_empty = grant_q[0] ? bus.a_empty : bus.b_empty;
  assign pick_a    = !bus.a_empty
                   && (bus.b_empty || !prio_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    prio_d  = prio_q;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (!bus.a_empty || !bus.b_empty) begin
          grant_d = pick_a ? 2'b01 : 2'b10;
          cnt_d   = '0;
          state_d = RD;
        end
      end
      RD: state_d = LOAD;
      LOAD: begin
        data_d  = grant_q[0] ? bus.a_data
                             : bus.b_data;
        state_d = SEND;
      end
      SEND, WAIT: begin
        state_d = WAIT;
        if (bus.tx_done) begin
          cnt_d = cnt_inc;
          if (cnt_inc == LenLimit || own_empty) begin
            // hand priority to whoever did not own this burst
            grant_d = '0;
            prio_d  = grant_q[0];
            state_d = IDLE;
          end else begin
            state_d = RD;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign bus.a_rd_en  = (state_q == RD) && grant_q[0];
  assign bus.b_rd_en  = (state_q == RD) && grant_q[1];
  assign bus.tx_valid = (state_q == SEND)
                     || (state_q == WAIT);
  assign bus.tx_data  = data_q;
  assign bus.grant    = grant_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: instance 0 runs with PKT_LEN 32, instance 1 with
// PKT_LEN 2; each has two small FIFO models feeding it.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_arbiter_if bus [2] ();

  logic [7:0] mem [2][2][16];
  logic [3:0] wp  [2][2];
  logic       done_v [2];

  logic       vld  [2];
  logic [7:0] txd  [2];
  logic [1:0] gnt  [2];
  logic       bsy  [2];
  logic [1:0] rdv  [2];
  int         rda  [2];
  int         rdb  [2];

  int vectors = 0;
  int errors  = 0;

  for (genvar g = 0; g < 2; g++) begin : gen_d
    logic [3:0] ra = '0;
    logic [3:0] rb = '0;
    logic [7:0] ad = '0;
    logic [7:0] bd = '0;
    int         na = 0;
    int         nb = 0;

    uart_tx_arbiter #(
      .PKT_LEN (g == 0 ? 32 : 2)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus[g])
    );

    always @(posedge clk) begin
      if (bus[g].a_rd_en) begin
        ad <= mem[g][0][ra];
        ra <= ra + 4'd1;
        na <= na + 1;
      end
      if (bus[g].b_rd_en) begin
        bd <= mem[g][1][rb];
        rb <= rb + 4'd1;
        nb <= nb + 1;
      end
    end

    assign bus[g].a_empty = (ra == wp[g][0]);
    assign bus[g].b_empty = (rb == wp[g][1]);
    assign bus[g].a_data  = ad;
    assign bus[g].b_data  = bd;
    assign bus[g].tx_done = done_v[g];

    assign vld[g] = bus[g].tx_valid;
    assign txd[g] = bus[g].tx_data;
    assign gnt[g] = bus[g].grant;
    assign bsy[g] = bus[g].busy;
    assign rdv[g] = {bus[g].b_rd_en, bus[g].a_rd_en};
    assign rda[g] = na;
    assign rdb[g] = nb;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input int r,
                      input logic [7:0] v);
    mem[d][r][wp[d][r]] = v;
    wp[d][r] = wp[d][r] + 4'd1;
  endtask

  // wait for a byte, hold tx_done off 5 cycles, then complete it
  task automatic xfer(input int d, input logic [7:0] data,
                      input logic [1:0] g, input string tag);
    int n = 0;
    while (!vld[d] && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(vld[d]), 32'd1);
    chk({tag, "_data"}, 32'(txd[d]), 32'(data));
    chk({tag, "_grant"}, 32'(gnt[d]), 32'(g));
    repeat (5) tick();
    chk({tag, "_hold"}, {23'd0, vld[d], txd[d]},
        {23'd0, 1'b1, data});
    done_v[d] = 1'b1;
    tick();
    done_v[d] = 1'b0;
    chk({tag, "_drop"}, 32'(vld[d]), 32'd0);
  endtask

  initial begin
    int a0, b0;
    reset     = 1'b0;
    done_v[0] = 1'b0;
    done_v[1] = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 2; r++)
        wp[d][r] = '0;
    tick();
    tick();

    chk("rst_valid", 32'(vld[0]), 32'd0);
    chk("rst_data", 32'(txd[0]), 32'd0);
    chk("rst_grant", 32'(gnt[0]), 32'd0);
    chk("rst_busy", 32'(bsy[0]), 32'd0);
    chk("rst_rd", 32'(rdv[0]), 32'd0);
    reset = 1'b1;
    tick();

    // three bytes from A, B empty
    a0 = rda[0];
    b0 = rdb[0];
    push(0, 0, 8'h11);
    push(0, 0, 8'h22);
    push(0, 0, 8'h33);
    tick();
    chk("lat_rd_t1", 32'(rdv[0]), 32'h1);
    chk("lat_grant_t1", 32'(gnt[0]), 32'h1);
    chk("lat_busy_t1", 32'(bsy[0]), 32'd1);
    tick();
    chk("lat_load_novalid", 32'(vld[0]), 32'd0);
    tick();
    chk("lat_valid_t3", 32'(vld[0]), 32'd1);
    xfer(0, 8'h11, 2'b01, "a1");
    xfer(0, 8'h22, 2'b01, "a2");
    xfer(0, 8'h33, 2'b01, "a3");
    chk("a3_release_grant", 32'(gnt[0]), 32'd0);
    chk("a3_release_busy", 32'(bsy[0]), 32'd0);
    chk("a_rd_pulses", rda[0] - a0, 32'd3);
    chk("b_rd_pulses", rdb[0] - b0, 32'd0);
    tick();
    chk("a3_stay_idle", 32'(bsy[0]), 32'd0);

    // tx_done during LOAD is ignored; sole requester wins over prio
    push(0, 0, 8'h44);
    tick();
    chk("ld_grant", 32'(gnt[0]), 32'h1);
    tick();
    done_v[0] = 1'b1;
    tick();
    done_v[0] = 1'b0;
    chk("ld_send_valid", 32'(vld[0]), 32'd1);
    chk("ld_send_data", 32'(txd[0]), 32'h44);
    tick();
    chk("ld_wait_valid", 32'(vld[0]), 32'd1);
    done_v[0] = 1'b1;
    tick();
    done_v[0] = 1'b0;
    chk("ld_done_valid", 32'(vld[0]), 32'd0);
    chk("ld_done_busy", 32'(bsy[0]), 32'd0);
    done_v[0] = 1'b1;
    tick();
    done_v[0] = 1'b0;
    chk("idle_done_ignored", 32'(bsy[0]), 32'd0);

    // A drains after one byte; B shows up mid-burst
    push(0, 0, 8'h55);
    tick();
    chk("drain_grant", 32'(gnt[0]), 32'h1);
    push(0, 1, 8'h66);
    tick();
    xfer(0, 8'h55, 2'b01, "drain");
    chk("drain_release", 32'(gnt[0]), 32'd0);
    push(0, 0, 8'h77);
    a0 = rda[0];
    tick();
    chk("rr_grant_b", 32'(gnt[0]), 32'h2);
    xfer(0, 8'h66, 2'b10, "rr_b");
    chk("rr_no_a_rd", rda[0] - a0, 32'd0);
    tick();
    chk("rr_grant_a", 32'(gnt[0]), 32'h1);
    xfer(0, 8'h77, 2'b01, "rr_a");

    // reset while a byte is waiting in WAIT
    push(0, 0, 8'h88);
    push(0, 0, 8'h99);
    tick();
    tick();
    tick();
    chk("mid_send_data", 32'(txd[0]), 32'h88);
    tick();
    chk("mid_wait_valid", 32'(vld[0]), 32'd1);
    reset = 1'b0;
    tick();
    chk("mid_rst_outs",
        {19'd0, vld[0], txd[0], gnt[0], bsy[0], rdv[0]},
        32'd0);
    reset = 1'b1;
    chk("mid_rel_no_rd", 32'(rdv[0]), 32'd0);
    tick();
    chk("mid_rel_rd_t1", 32'(rdv[0]), 32'h1);
    xfer(0, 8'h99, 2'b01, "mid_rel");

    // simultaneous arrival after reset
    reset = 1'b0;
    tick();
    reset = 1'b1;
    push(0, 0, 8'hA1);
    push(0, 1, 8'hB1);
    tick();
    chk("both_first_rd", 32'(rdv[0]), 32'h1);
    xfer(0, 8'hA1, 2'b01, "both_a");
    push(0, 0, 8'hA2);
    tick();
    chk("both_next_rd", 32'(rdv[0]), 32'h2);
    xfer(0, 8'hB1, 2'b10, "both_b");
    tick();
    chk("both_back_a", 32'(gnt[0]), 32'h1);
    xfer(0, 8'hA2, 2'b01, "both_a2");

    // PKT_LEN 2 instance: A,A,B,B,A,A,B,B
    for (int i = 0; i < 4; i++) begin
      push(1, 0, 8'(i + 1));
      push(1, 1, 8'(8'h81 + i));
    end
    tick();
    chk("pk_g1", 32'(gnt[1]), 32'h1);
    xfer(1, 8'h01, 2'b01, "pk_a1");
    xfer(1, 8'h02, 2'b01, "pk_a2");
    chk("pk_gap1", {30'd0, gnt[1]}, 32'd0);
    chk("pk_gap1_busy", 32'(bsy[1]), 32'd0);
    tick();
    chk("pk_g2", 32'(gnt[1]), 32'h2);
    xfer(1, 8'h81, 2'b10, "pk_b1");
    xfer(1, 8'h82, 2'b10, "pk_b2");
    chk("pk_gap2_busy", 32'(bsy[1]), 32'd0);
    tick();
    chk("pk_g3", 32'(gnt[1]), 32'h1);
    xfer(1, 8'h03, 2'b01, "pk_a3");
    xfer(1, 8'h04, 2'b01, "pk_a4");
    chk("pk_gap3_busy", 32'(bsy[1]), 32'd0);
    tick();
    chk("pk_g4", 32'(gnt[1]), 32'h2);
    xfer(1, 8'h83, 2'b10, "pk_b3");
    xfer(1, 8'h84, 2'b10, "pk_b4");
    tick();
    chk("pk_end_idle", {30'd0, gnt[1]}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
